regfile_scanner: RTL

//  Read-side sequencer for the 32x32 register file: sweeps a contiguous address

---
 rtl/regfile_scanner_if.sv | 28 ++
 rtl/regfile_scanner.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/regfile_scanner_if.sv
// Output stream of the register file scanner: one word per valid/ready
// handshake, tagged with its source address and an end-of-scan marker.
interface regfile_scanner_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_addr,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_addr,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/regfile_scanner.sv
// Read-side sequencer: sweeps an address window of the register file and
// streams the words through a 2-entry first-word-fall-through FIFO.
module regfile_scanner #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   count,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    regfile_scanner_if.master out_if
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   rem_q, rem_d;
    logic          prime_q, prime_d;
    logic          done_q, done_d;
    logic [1:0]    occ_q, occ_d;
    logic [DW-1:0] h_data_q, h_data_d;
    logic [AW-1:0] h_addr_q, h_addr_d;
    logic          h_last_q, h_last_d;
    logic [DW-1:0] t_data_q, t_data_d;
    logic [AW-1:0] t_addr_q, t_addr_d;
    logic          t_last_q, t_last_d;

    logic push;
    logic pop;
    logic can_push;
    logic in_last;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        prime_d  = prime_q;
        done_d   = 1'b0;
        push     = 1'b0;
        pop      = (occ_q != 2'd0) && out_if.out_ready;
        can_push = (occ_q != 2'd2) || pop;
        in_last  = (rem_q == (AW+1)'(1));

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        addr_d  = base_addr;
                        rem_d   = count;
                        prime_d = 1'b1;
                        state_d = SCAN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                // First SCAN cycle only settles the freshly loaded address.
                if (prime_q) begin
                    prime_d = 1'b0;
                end else if (can_push) begin
                    push   = 1'b1;
                    addr_d = addr_q + AW'(1);
                    rem_d  = rem_q - (AW+1)'(1);
                    if (in_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && occ_q == 2'd1) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        occ_d    = occ_q;
        h_data_d = h_data_q;
        h_addr_d = h_addr_q;
        h_last_d = h_last_q;
        t_data_d = t_data_q;
        t_addr_d = t_addr_q;
        t_last_d = t_last_q;

        case ({push, pop})
            2'b10: begin
                occ_d = occ_q + 2'd1;
                if (occ_q == 2'd0) begin
                    h_data_d = rd_data;
                    h_addr_d = addr_q;
                    h_last_d = in_last;
                end else begin
                    t_data_d = rd_data;
                    t_addr_d = addr_q;
                    t_last_d = in_last;
                end
            end
            2'b01: begin
                occ_d = occ_q - 2'd1;
                if (occ_q == 2'd2) begin
                    h_data_d = t_data_q;
                    h_addr_d = t_addr_q;
                    h_last_d = t_last_q;
                end
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    h_data_d = rd_data;
                    h_addr_d = addr_q;
                    h_last_d = in_last;
                end else begin
                    h_data_d = t_data_q;
                    h_addr_d = t_addr_q;
                    h_last_d = t_last_q;
                    t_data_d = rd_data;
                    t_addr_d = addr_q;
                    t_last_d = in_last;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            prime_q  <= 1'b0;
            done_q   <= 1'b0;
            occ_q    <= 2'd0;
            h_data_q <= '0;
            h_addr_q <= '0;
            h_last_q <= 1'b0;
            t_data_q <= '0;
            t_addr_q <= '0;
            t_last_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            prime_q  <= prime_d;
            done_q   <= done_d;
            occ_q    <= occ_d;
            h_data_q <= h_data_d;
            h_addr_q <= h_addr_d;
            h_last_q <= h_last_d;
            t_data_q <= t_data_d;
            t_addr_q <= t_addr_d;
            t_last_q <= t_last_d;
        end
    end

    assign rd_addr          = addr_q;
    assign busy             = (state_q != IDLE);
    assign done             = done_q;
    assign out_if.out_valid = (occ_q != 2'd0);
    assign out_if.out_data  = h_data_q;
    assign out_if.out_addr  = h_addr_q;
    assign out_if.out_last  = h_last_q;

endmodule
